// File: rtl/ftoi_pkg.sv
// rtl/ftoi_pkg.sv - shared types and constants for the float-to-int pipeline
// Optional FTOI_PIPE_FLAGS_EN adds the subnormal-flush marker to the stage-1 record.
package ftoi_pkg;

  typedef enum logic [1:0] {
    RNE = 2'b00,
    RTZ = 2'b01,
    RDN = 2'b10,
    RUP = 2'b11
  } rm_e;

  localparam int F32_BIAS = 127;
  localparam int F32_EXP_W = 8;
  localparam int F32_MAN_W = 23;
  localparam logic [F32_EXP_W-1:0] F32_EXP_SPECIAL = 8'hFF;

  // Magnitude sized for the widest legal OUT_W (64) plus a rounding carry.
  localparam int MAG_W = 65;

  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
    logic             guard;
    logic             sticky;
    rm_e              rm;
    logic             nan;
    logic             inf;
    logic             big;
`ifdef FTOI_PIPE_FLAGS_EN
    logic             sub_nz;
`endif
  } ftoi_s1_t;

endpackage

// File: rtl/ftoi_round.sv
// rtl/ftoi_round.sv - IEEE rounding increment decision from sign, lsb, guard and sticky
// Purely combinational so it can be shared with the int-to-float direction.
module ftoi_round
  import ftoi_pkg::*;
(
  input  logic [1:0] rm,
  input  logic       sign,
  input  logic       lsb,
  input  logic       guard,
  input  logic       sticky,
  output logic       increment
);

  always_comb begin
    increment = 1'b0;
    case (rm_e'(rm))
      RNE:     increment = guard && (sticky || lsb);
      RTZ:     increment = 1'b0;
      RDN:     increment = sign && (guard || sticky);
      RUP:     increment = !sign && (guard || sticky);
      default: increment = 1'b0;
    endcase
  end

endmodule

// File: rtl/ftoi_pipe.sv
// rtl/ftoi_pipe.sv - two-stage binary32 to signed integer converter with valid/ready
// Define FTOI_PIPE_FLAGS_EN to add the registered {invalid, inexact} flags output.
module ftoi_pipe
  import ftoi_pkg::*;
#(
  parameter int OUT_W = 32,
  parameter int FTZ   = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x,
  input  logic [1:0]       rm,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef FTOI_PIPE_FLAGS_EN
  output logic [1:0]       flags,
`endif
  output logic [OUT_W-1:0] y
);

  localparam logic signed [9:0] OUT_W_S  = 10'(OUT_W);
  localparam logic signed [9:0] BIAS_S   = 10'(F32_BIAS);
  localparam logic signed [9:0] MAN_W_S  = 10'(F32_MAN_W);
  localparam logic [MAG_W-1:0]  LIM_NEG  = MAG_W'(1) << (OUT_W - 1);
  localparam logic [MAG_W-1:0]  LIM_POS  = LIM_NEG - MAG_W'(1);
  localparam logic [OUT_W-1:0]  MAX_POS  = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]  MIN_NEG  = {1'b1, {(OUT_W-1){1'b0}}};

  logic     v1, v2;
  logic     s1_adv, s2_adv;
  ftoi_s1_t s1_d, s1_q;

  assign s2_adv    = !v2 || out_ready;
  assign s1_adv    = !v1 || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = v2;

  // Stage 1: decode and align
  logic [F32_EXP_W-1:0] e_x;
  logic [F32_MAN_W-1:0] m_x;
  logic                 sub;
  logic [23:0]          sig;
  logic signed [9:0]    exp_u;
  logic [47:0]          ext, shr;
  logic [5:0]           lsh, rsh;

  assign e_x   = x[30:23];
  assign m_x   = x[22:0];
  assign sub   = (e_x == '0);
  assign sig   = (sub && (FTZ != 0)) ? 24'd0 : {!sub, m_x};
  assign exp_u = $signed({2'b00, e_x}) - BIAS_S;
  assign ext   = {sig, 24'd0};

  always_comb begin
    s1_d        = '0;
    lsh         = '0;
    rsh         = '0;
    shr         = '0;
    s1_d.sign   = x[31];
    s1_d.rm     = rm_e'(rm);
    s1_d.nan    = (e_x == F32_EXP_SPECIAL) && (m_x != '0);
    s1_d.inf    = (e_x == F32_EXP_SPECIAL) && (m_x == '0);
    s1_d.big    = (exp_u >= OUT_W_S);
`ifdef FTOI_PIPE_FLAGS_EN
    s1_d.sub_nz = sub && (m_x != '0) && (FTZ != 0);
`endif
    if (s1_d.big) begin
      s1_d.mag = '0;
    end else if (exp_u >= MAN_W_S) begin
      lsh      = 6'(exp_u - MAN_W_S);
      s1_d.mag = MAG_W'(sig) << lsh;
    end else if (exp_u >= -10'sd1) begin
      // Right shift of 1..24: bit 23 of the shifted window lands in guard.
      rsh         = 6'(MAN_W_S - exp_u);
      shr         = ext >> rsh;
      s1_d.mag    = MAG_W'(shr[47:24]);
      s1_d.guard  = shr[23];
      s1_d.sticky = |shr[22:0];
    end else begin
      s1_d.sticky = |sig;
    end
  end

  // Stage 2: round, negate, saturate
  logic             inc;
  logic [MAG_W-1:0] rnd;
  logic             ovf;
  logic [OUT_W-1:0] y_d;

  ftoi_round u_round (
    .rm        (s1_q.rm),
    .sign      (s1_q.sign),
    .lsb       (s1_q.mag[0]),
    .guard     (s1_q.guard),
    .sticky    (s1_q.sticky),
    .increment (inc)
  );

  assign rnd = s1_q.mag + MAG_W'(inc);
  assign ovf = s1_q.sign ? (rnd > LIM_NEG) : (rnd > LIM_POS);

  always_comb begin
    y_d = '0;
    if (s1_q.nan) begin
      y_d = MAX_POS;
    end else if (s1_q.inf || s1_q.big || ovf) begin
      y_d = s1_q.sign ? MIN_NEG : MAX_POS;
    end else if (s1_q.sign) begin
      y_d = -rnd[OUT_W-1:0];
    end else begin
      y_d = rnd[OUT_W-1:0];
    end
  end

`ifdef FTOI_PIPE_FLAGS_EN
  logic       invalid_d;
  logic [1:0] flags_d;
  assign invalid_d = s1_q.nan || s1_q.inf || s1_q.big || ovf;
  assign flags_d   = {invalid_d, !invalid_d && (s1_q.guard || s1_q.sticky || s1_q.sub_nz)};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flags <= '0;
    end else if (s2_adv && v1) begin
      flags <= flags_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      s1_q <= '0;
      y    <= '0;
    end else begin
      if (s1_adv) begin
        v1 <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_adv) begin
        v2 <= v1;
        if (v1) y <= y_d;
      end
    end
  end

endmodule

// File: tb/tb_ftoi_pipe.sv
// tb/tb_ftoi_pipe.sv - directed vector bench for ftoi_pipe at OUT_W=32 and OUT_W=16
module tb_ftoi_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        a_iv, a_ir, a_ov, a_or;
  logic [31:0] a_x, a_y;
  logic [1:0]  a_rm;
  logic        b_iv, b_ir, b_ov, b_or;
  logic [31:0] b_x;
  logic [15:0] b_y;
  logic [1:0]  b_rm;
`ifdef FTOI_PIPE_FLAGS_EN
  logic [1:0]  a_fl, b_fl;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ftoi_pipe #(.OUT_W(32), .FTZ(1)) u32 (
    .clk(clk), .rstn(rstn), .in_valid(a_iv), .in_ready(a_ir), .x(a_x), .rm(a_rm),
    .out_valid(a_ov), .out_ready(a_or),
`ifdef FTOI_PIPE_FLAGS_EN
    .flags(a_fl),
`endif
    .y(a_y));

  ftoi_pipe #(.OUT_W(16), .FTZ(1)) u16 (
    .clk(clk), .rstn(rstn), .in_valid(b_iv), .in_ready(b_ir), .x(b_x), .rm(b_rm),
    .out_valid(b_ov), .out_ready(b_or),
`ifdef FTOI_PIPE_FLAGS_EN
    .flags(b_fl),
`endif
    .y(b_y));

  typedef struct {
    bit          w16;
    logic [31:0] x;
    logic [1:0]  rm;
    logic [63:0] y;
    logic [1:0]  fl;
  } vec_t;

  vec_t vt[$];

  function automatic void add(bit w, logic [31:0] xv, logic [1:0] r, logic [63:0] yv, logic [1:0] f);
    vec_t v;
    v.w16 = w; v.x = xv; v.rm = r; v.y = yv; v.fl = f;
    vt.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // Called at posedge+1 with an idle pipeline; sends one operand and collects it.
  task automatic apply(input vec_t v, input string nm);
    int cyc;
    logic [63:0] got;
    if (v.w16) begin b_iv = 1; b_x = v.x; b_rm = v.rm; b_or = 1; end
    else       begin a_iv = 1; a_x = v.x; a_rm = v.rm; a_or = 1; end
    @(posedge clk); #1;
    a_iv = 0; b_iv = 0;
    cyc = 0;
    while (!(v.w16 ? b_ov : a_ov) && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({nm, "_lat"}, 64'(cyc), 64'd1);
    got = v.w16 ? {48'd0, b_y} : {32'd0, a_y};
    check({nm, "_y"}, got, v.y);
`ifdef FTOI_PIPE_FLAGS_EN
    check({nm, "_fl"}, 64'(v.w16 ? b_fl : a_fl), 64'(v.fl));
`endif
    @(posedge clk); #1;
    check({nm, "_drain"}, 64'(v.w16 ? b_ov : a_ov), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] fv [8];
    bit m1, m2, s1a, s2a, emit, acc;
    int d1, d2, sent, recv;
    vec_t one;

    fv = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
           32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    rstn = 0;
    a_iv = 0; a_or = 1; a_x = '0; a_rm = '0;
    b_iv = 0; b_or = 1; b_x = '0; b_rm = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ov32", 64'(a_ov), 64'd0);
    check("rst_y32", 64'(a_y), 64'd0);
    check("rst_ov16", 64'(b_ov), 64'd0);
    check("rst_y16", 64'(b_y), 64'd0);
    rstn = 1;
    @(posedge clk); #1;
    check("rst_ir32", 64'(a_ir), 64'd1);
    check("rst_ir16", 64'(b_ir), 64'd1);

    add(0, 32'h3FC00000, 2'd0, 64'd2, 2'b01);
    add(0, 32'h3FC00000, 2'd1, 64'd1, 2'b01);
    add(0, 32'h3FC00000, 2'd2, 64'd1, 2'b01);
    add(0, 32'h3FC00000, 2'd3, 64'd2, 2'b01);
    add(0, 32'h40200000, 2'd0, 64'd2, 2'b01);
    add(0, 32'h40200000, 2'd1, 64'd2, 2'b01);
    add(0, 32'h40200000, 2'd2, 64'd2, 2'b01);
    add(0, 32'h40200000, 2'd3, 64'd3, 2'b01);
    add(0, 32'hBFC00000, 2'd0, 64'hFFFFFFFE, 2'b01);
    add(0, 32'hBFC00000, 2'd1, 64'hFFFFFFFF, 2'b01);
    add(0, 32'hBFC00000, 2'd2, 64'hFFFFFFFE, 2'b01);
    add(0, 32'hBFC00000, 2'd3, 64'hFFFFFFFF, 2'b01);
    add(0, 32'h4F000000, 2'd0, 64'h7FFFFFFF, 2'b10);
    add(0, 32'hCF000000, 2'd0, 64'h80000000, 2'b00);
    add(0, 32'h4EFFFFFF, 2'd0, 64'h7FFFFF80, 2'b00);
    add(0, 32'h7FC00000, 2'd0, 64'h7FFFFFFF, 2'b10);
    add(0, 32'hFFC00000, 2'd2, 64'h7FFFFFFF, 2'b10);
    add(0, 32'hFF800000, 2'd0, 64'h80000000, 2'b10);
    add(0, 32'h7F800000, 2'd1, 64'h7FFFFFFF, 2'b10);
    add(0, 32'h60AD78EC, 2'd0, 64'h7FFFFFFF, 2'b10);
    add(0, 32'hE0AD78EC, 2'd3, 64'h80000000, 2'b10);
    add(0, 32'h3F000000, 2'd0, 64'd0, 2'b01);
    add(0, 32'h3F000000, 2'd3, 64'd1, 2'b01);
    add(0, 32'h3EFFFFFF, 2'd0, 64'd0, 2'b01);
    add(0, 32'h00000001, 2'd3, 64'd0, 2'b01);
    add(0, 32'h80000001, 2'd2, 64'd0, 2'b01);
    add(0, 32'h80000000, 2'd2, 64'd0, 2'b00);
    add(1, 32'h46FFFE00, 2'd0, 64'h7FFF, 2'b00);
    add(1, 32'h46FFFF00, 2'd0, 64'h7FFF, 2'b10);
    add(1, 32'h46FFFF00, 2'd1, 64'h7FFF, 2'b01);
    add(1, 32'hC7000000, 2'd0, 64'h8000, 2'b00);
    add(1, 32'h47000000, 2'd0, 64'h7FFF, 2'b10);
    add(1, 32'hBFC00000, 2'd0, 64'hFFFE, 2'b01);

    foreach (vt[i]) apply(vt[i], $sformatf("vec%0d", i));

    // Back-pressure: 8 back-to-back operands 1.0..8.0, out_ready pattern 1,0,0,1
    m1 = 0; m2 = 0; d1 = 0; d2 = 0; sent = 0; recv = 0;
    for (int c = 0; c < 60 && recv < 8; c++) begin
      a_or = ((c % 4) == 0) || ((c % 4) == 3);
      a_iv = (sent < 8);
      a_x  = fv[sent % 8];
      a_rm = 2'd0;
      #1;
      check($sformatf("bp_ready_c%0d", c), 64'(a_ir), 64'(!m1 || !m2 || a_or));
      check($sformatf("bp_valid_c%0d", c), 64'(a_ov), 64'(m2));
      if (m2) check($sformatf("bp_y_c%0d", c), 64'(a_y), 64'(d2 + 1));
      s2a  = !m2 || a_or;
      s1a  = !m1 || s2a;
      emit = m2 && a_or;
      acc  = a_iv && s1a;
      if (emit) recv++;
      if (s2a) begin m2 = m1; d2 = d1; end
      if (s1a) begin m1 = a_iv; d1 = sent; end
      if (acc) sent++;
      @(posedge clk); #1;
    end
    a_iv = 0; a_or = 1;
    check("bp_count", 64'(recv), 64'd8);

    // Reset with both stages full
    a_or = 0; a_iv = 1; a_x = fv[0];
    @(posedge clk); #1;
    a_x = fv[1];
    @(posedge clk); #1;
    a_iv = 0;
    check("full_ov", 64'(a_ov), 64'd1);
    check("full_ir", 64'(a_ir), 64'd0);
    #2 rstn = 0;
    #1;
    check("rst_async_ov", 64'(a_ov), 64'd0);
    @(posedge clk); #1;
    rstn = 1; a_or = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("rst_stale%0d", k), 64'(a_ov), 64'd0);
    end
    one.w16 = 0; one.x = 32'h40400000; one.rm = 2'd1; one.y = 64'd3; one.fl = 2'b00;
    apply(one, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ftoi_pipe.md
Name: ftoi_pipe

Overview:
- Pipelined, parametrised single-precision float to signed-integer converter for the FPU datapath.
- Successor to the combinational float-to-int converter. Adds selectable IEEE rounding modes, configurable output width, saturation on overflow/NaN, and a valid/ready handshake with full back-pressure.
- Sits between the FPU issue stage and the integer writeback path.

Parameters:
- OUT_W, 32, integer result width in bits; legal range 16..64.
- FTZ, 1, 1 = subnormal inputs are flushed to zero before conversion; 0 = subnormals are converted (result 0 or ±1 depending on rounding).

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  operand valid
- in_ready  out  1  converter can accept an operand this cycle
- x  in  32  IEEE-754 binary32 operand
- rm  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN, 11 RUP
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- y  out  OUT_W  two's-complement result

Behaviour:
- Interface: one clock, clk. Reset rstn is asynchronous and active-low.
- Reset: out_valid=0, y=0, both stage-valid bits cleared. When rstn asserts mid-operation, all in-flight operands are dropped with no output. in_ready=1 from the first cycle after reset.
- Transfers:
  - An input is accepted on a clk edge with in_valid&&in_ready.
  - An output is consumed on a clk edge with out_valid&&out_ready.
  - x and rm are captured together.
- Pipeline:
  - Two registered stages, so latency is exactly 2 cycles when there is no stall. An operand accepted at edge N is presented at edge N+2.
  - Throughput is one result per cycle.
- Stall rules:
  - s2 advances when !v2||out_ready.
  - s1 advances when !v1||s2_advance.
  - in_ready = !v1||s2_advance.
  - While stalled, y and out_valid hold stable.
  - Results are never dropped or duplicated.
  - Simultaneous accept and emit in the same cycle is legal.
- Stage 1 (decode and align):
  - Split x into s, e[7:0], m[22:0]. Significand is {1,m}, or {0,m} for a subnormal when FTZ=0.
  - Unbiased exponent E = e-127.
  - Magnitude integer = significand shifted by E-23, computed in OUT_W+1 bits.
  - Keep guard = first discarded bit and sticky = OR of the remaining discarded bits. A shift that discards all bits puts the whole significand into guard/sticky.
  - Flag NaN (e=255, m≠0), Inf (e=255, m=0), and big (E≥OUT_W).
- Stage 2 (round, negate, saturate):
  - Increment decision:
    - RNE: guard&&(sticky||lsb)
    - RTZ: 0
    - RDN: s&&(guard||sticky)
    - RUP: !s&&(guard||sticky)
  - Rounded magnitude is OUT_W+1 bits wide, so a carry out is kept. Negate when s=1.
  - Overflow: magnitude > 2^(OUT_W-1)-1 for positive results, or > 2^(OUT_W-1) for negative results. This includes magnitudes reached through rounding, e.g. 2^(OUT_W-1)-0.5 under RNE.
  - Saturation values: positive overflow and +Inf give 2^(OUT_W-1)-1; negative overflow and -Inf give -2^(OUT_W-1); NaN of either sign gives 2^(OUT_W-1)-1.
  - ±0 gives 0. When FTZ=1, any subnormal gives 0 for every rm.
- The shift amount is fully range-checked; there is no modulo-32 shift wrap.

Optional Feature:
- Macro: FTOI_PIPE_FLAGS_EN.
- Defined:
  - Adds output port flags[1:0] = {invalid, inexact}, registered alongside y and held while stalled.
  - invalid is set for NaN, ±Inf or overflow; inexact is not set when invalid is set.
  - inexact = guard||sticky on an in-range result. When FTZ=1 it is also set for a nonzero subnormal.
  - Reset value: flags=0.
- Undefined: the port and its logic are absent; y is identical in both builds.

Decomposition:
- Package ftoi_pkg:
  - rm_e enum (RNE/RTZ/RDN/RUP)
  - F32_BIAS=127, F32_EXP_W=8, F32_MAN_W=23, F32_EXP_SPECIAL=8'hFF
  - struct ftoi_s1_t for the stage-1 register (sign, magnitude, guard, sticky, rm, nan/inf/big flags)
- Sub-module ftoi_round: combinational; inputs rm, sign, lsb, guard, sticky; output increment. Shared with a future itof block.

Test Plan:
- 1.5 (0x3FC00000), 2.5 (0x40200000) and -1.5 (0xBFC00000) under all four rm: 1.5 -> RNE 2, RTZ 1, RDN 1, RUP 2. 2.5 -> RNE 2, RUP 3. -1.5 -> RDN 0xFFFFFFFE, RTZ 0xFFFFFFFF, RUP 0xFFFFFFFF. OUT_W=32; flags inexact=1 in every case.
- Saturation at OUT_W=32: 0x4F000000 (2^31) -> 0x7FFFFFFF with invalid. 0xCF000000 (-2^31) -> 0x80000000 with flags=00. 0x7FC00000 (NaN) -> 0x7FFFFFFF with invalid. 0xFF800000 (-Inf) -> 0x80000000.
- Small values: 0x3F000000 (0.5) RNE -> 0, RUP -> 1. 0x3EFFFFFF RNE -> 0. With FTZ=1, 0x00000001 under RUP -> 0.
- Back-pressure: stream 8 back-to-back operands with out_ready toggling 1,0,0,1,... Require results in order with no loss or duplication, y stable while stalled, in_ready=0 only when both stages are full and out_ready=0, and results 2 cycles after acceptance when unstalled.
- Reset: assert rstn low with both stages full. Require out_valid=0 immediately (asynchronously); after release, no stale result appears and the next operand emerges 2 cycles after acceptance.
- Width: OUT_W=16 with 0x46FFFE00 (32767) -> 0x7FFF. 0x46FFFF00 (32767.5) under RNE rounds to 32768 -> 0x7FFF with invalid. 0xC7000000 (-32768) -> 0x8000 exact.
